// File: rtl/cola_vend_ctrl_if.sv
// Handshake bundle between the cola vending controller and its coin, dispenser and operator peripherals.
interface cola_vend_ctrl_if;
  logic       pi_money_half;
  logic       pi_money_one;
  logic       pi_cancel;
  logic       pi_refill;
  logic       pi_disp_ack;
  logic       po_cola;
  logic       po_money;
  logic       po_reject;
  logic [3:0] po_credit;
  logic       po_empty;

  modport master (
    output pi_money_half, pi_money_one, pi_cancel, pi_refill, pi_disp_ack,
    input  po_cola, po_money, po_reject, po_credit, po_empty
  );

  modport slave (
    input  pi_money_half, pi_money_one, pi_cancel, pi_refill, pi_disp_ack,
    output po_cola, po_money, po_reject, po_credit, po_empty
  );
endinterface

// File: rtl/cola_vend_ctrl.sv
// Cola vending sequencer: credit accumulation in half-units, dispense handshake,
// change/refund pulse train and stock tracking. All outputs are registered.
module cola_vend_ctrl #(
  parameter int PRICE      = 5,
  parameter int STOCK_INIT = 8,
  parameter int TIMEOUT    = 1000
) (
  input  logic           sys_clk,
  input  logic           sys_rst_n,
  cola_vend_ctrl_if.slave bus
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [4:0]    PRICE_W  = 5'(PRICE);
  localparam logic [3:0]    STOCK_W  = 4'(STOCK_INIT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    IDLE     = 4'b0001,
    ACCUM    = 4'b0010,
    DISPENSE = 4'b0100,
    REFUND   = 4'b1000
  } state_t;

  state_t        state, state_nxt;
  logic [3:0]    credit, credit_nxt;
  logic [3:0]    stock, stock_nxt;
  logic [TW-1:0] tmo, tmo_nxt;
  logic          money_q, money_nxt;
  logic          reject_q, reject_nxt;
  logic          cola_q;
  logic          empty_q;

  logic          coin;
  logic [1:0]    coin_val;
  logic [4:0]    sum;

  assign coin     = bus.pi_money_half | bus.pi_money_one;
  assign coin_val = {bus.pi_money_one, bus.pi_money_half};
  assign sum      = {1'b0, credit} + {3'b000, coin_val};

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit;
    stock_nxt  = stock;
    tmo_nxt    = '0;
    money_nxt  = 1'b0;
    reject_nxt = 1'b0;
    case (state)
      IDLE: begin
        if (coin) begin
          if (stock == 4'd0) begin
            reject_nxt = 1'b1;
          end else if (sum >= PRICE_W) begin
            credit_nxt = 4'(sum - PRICE_W);
            state_nxt  = DISPENSE;
          end else begin
            credit_nxt = sum[3:0];
            state_nxt  = ACCUM;
          end
        end
        if (bus.pi_refill) stock_nxt = STOCK_W;
      end
      ACCUM: begin
        // A completing coin wins over a same-cycle cancel.
        if (sum >= PRICE_W) begin
          credit_nxt = 4'(sum - PRICE_W);
          state_nxt  = DISPENSE;
        end else if (bus.pi_cancel) begin
          credit_nxt = sum[3:0];
          state_nxt  = REFUND;
        end else if (coin) begin
          credit_nxt = sum[3:0];
        end else if (tmo == TMO_LAST) begin
          state_nxt = REFUND;
        end else begin
          tmo_nxt = tmo + 1'b1;
        end
      end
      DISPENSE: begin
        reject_nxt = coin;
        if (bus.pi_disp_ack) begin
          stock_nxt = stock - 4'd1;
          if (credit != 4'd0) begin
            money_nxt  = 1'b1;
            credit_nxt = credit - 4'd1;
            state_nxt  = REFUND;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      REFUND: begin
        // Pulses only follow a low cycle, so po_money never stays high twice.
        reject_nxt = coin;
        if (!money_q && credit != 4'd0) begin
          money_nxt  = 1'b1;
          credit_nxt = credit - 4'd1;
        end else if (credit == 4'd0) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt  = IDLE;
        credit_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      credit   <= 4'd0;
      stock    <= STOCK_W;
      tmo      <= '0;
      money_q  <= 1'b0;
      reject_q <= 1'b0;
      cola_q   <= 1'b0;
      empty_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit   <= credit_nxt;
      stock    <= stock_nxt;
      tmo      <= tmo_nxt;
      money_q  <= money_nxt;
      reject_q <= reject_nxt;
      cola_q   <= (state_nxt == DISPENSE);
      empty_q  <= (stock_nxt == 4'd0);
    end
  end

  assign bus.po_cola   = cola_q;
  assign bus.po_money  = money_q;
  assign bus.po_reject = reject_q;
  assign bus.po_credit = credit;
  assign bus.po_empty  = empty_q;

endmodule

// File: tb/tb_cola_vend_ctrl.sv
// Self-checking bench for cola_vend_ctrl: directed scenarios plus randomized traffic,
// all compared against a transaction-level vending model.
module tb_cola_vend_ctrl;
  localparam int PRICE      = 5;
  localparam int STOCK_INIT = 8;
  localparam int TIMEOUT    = 1000;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  cola_vend_ctrl_if bus();

  cola_vend_ctrl #(.PRICE(PRICE), .STOCK_INIT(STOCK_INIT), .TIMEOUT(TIMEOUT)) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus      (bus)
  );

  always #5 sys_clk = ~sys_clk;

  logic [7:0] dut_vec;
  assign dut_vec = {bus.po_cola, bus.po_money, bus.po_reject, bus.po_credit, bus.po_empty};

  // Machine-level view: credit held, stock, whether a cola or a payout is pending.
  int         m_credit, m_stock, m_idle;
  bit         m_vending, m_paying, m_last_money;
  logic [7:0] exp_vec;

  task automatic model_reset();
    m_credit = 0; m_stock = STOCK_INIT; m_idle = 0;
    m_vending = 0; m_paying = 0; m_last_money = 0;
    exp_vec = 8'h00;
  endtask

  task automatic model_step(input logic h, input logic o, input logic c, input logic r, input logic a);
    int cv, sum;
    bit mny, rej;
    cv  = int'(h) + 2 * int'(o);
    sum = m_credit + cv;
    mny = 0; rej = 0;
    if (m_vending) begin
      rej = (cv != 0);
      if (a) begin
        m_stock--; m_vending = 0;
        if (m_credit > 0) begin m_credit--; mny = 1; m_paying = 1; end
      end
    end else if (m_paying) begin
      rej = (cv != 0);
      if (!m_last_money && m_credit > 0) begin m_credit--; mny = 1; end
      else if (m_credit == 0) m_paying = 0;
    end else if (m_credit == 0) begin
      if (cv != 0) begin
        if (m_stock == 0) rej = 1;
        else begin
          m_idle = 0;
          if (sum >= PRICE) begin m_credit = sum - PRICE; m_vending = 1; end
          else m_credit = sum;
        end
      end
      if (r) m_stock = STOCK_INIT;
    end else begin
      if (sum >= PRICE) begin m_credit = sum - PRICE; m_vending = 1; m_idle = 0; end
      else if (c) begin m_credit = sum; m_paying = 1; m_idle = 0; end
      else if (cv != 0) begin m_credit = sum; m_idle = 0; end
      else begin
        m_idle++;
        if (m_idle == TIMEOUT) begin m_paying = 1; m_idle = 0; end
      end
    end
    m_last_money = mny;
    exp_vec = {m_vending, mny, rej, 4'(m_credit), (m_stock == 0)};
  endtask

  task automatic drive_cycle(input logic h, input logic o, input logic c, input logic r, input logic a);
    bus.pi_money_half = h; bus.pi_money_one = o; bus.pi_cancel = c;
    bus.pi_refill = r; bus.pi_disp_ack = a;
    @(posedge sys_clk);
    model_step(h, o, c, r, a);
    #1;
  endtask

  task automatic test_reset();
    bus.pi_money_half = 0; bus.pi_money_one = 0; bus.pi_cancel = 0;
    bus.pi_refill = 0; bus.pi_disp_ack = 0;
    sys_rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (dut_vec !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_outputs: got %b expected %b", dut_vec, 8'h00);
    end
    sys_rst_n = 1'b1;
    drive_cycle(0, 0, 0, 0, 0);
    checks++;
    if (dut_vec !== exp_vec) begin
      errors++; $display("[TB] FAIL reset_idle: got %b expected %b", dut_vec, exp_vec);
    end
  endtask

  task automatic test_half_coins();
    int pulses = 0;
    for (int i = 0; i < 5; i++) begin
      for (int k = 0; k < 3; k++) begin
        drive_cycle(k == 0, 0, 0, 0, 0);
        checks++;
        if (dut_vec !== exp_vec) begin
          errors++; $display("[TB] FAIL half_coins i%0d k%0d: got %b expected %b", i, k, dut_vec, exp_vec);
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      drive_cycle(0, 0, 0, 0, k == 1);
      pulses += int'(bus.po_money);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL half_coins_ack k%0d: got %b expected %b", k, dut_vec, exp_vec);
      end
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("[TB] FAIL half_coins_change: got %0d pulses expected 0", pulses);
    end
  endtask

  task automatic test_one_coins();
    int pulses = 0;
    for (int k = 0; k < 12; k++) begin
      drive_cycle(0, (k == 0) || (k == 2) || (k == 4), 0, 0, k == 7);
      pulses += int'(bus.po_money);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL one_coins k%0d: got %b expected %b", k, dut_vec, exp_vec);
      end
    end
    checks++;
    if (pulses !== 1 || bus.po_credit !== 4'd0) begin
      errors++; $display("[TB] FAIL one_coins_change: got %0d pulses credit %0d expected 1 and 0", pulses, bus.po_credit);
    end
  endtask

  task automatic test_cancel();
    int pulses = 0;
    bit back_to_back = 0;
    bit prev = 0;
    for (int k = 0; k < 10; k++) begin
      drive_cycle(0, k == 0, k == 2, 0, 0);
      pulses += int'(bus.po_money);
      if (prev && bus.po_money) back_to_back = 1;
      prev = bus.po_money;
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL cancel k%0d: got %b expected %b", k, dut_vec, exp_vec);
      end
    end
    checks++;
    if (pulses !== 2 || back_to_back) begin
      errors++; $display("[TB] FAIL cancel_refund: got %0d pulses adjacent=%0d expected 2 and 0", pulses, back_to_back);
    end
  endtask

  task automatic test_timeout();
    int pulses = 0;
    for (int k = 0; k < TIMEOUT + 8; k++) begin
      drive_cycle(k == 0, 0, 0, 0, 0);
      pulses += int'(bus.po_money);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL timeout k%0d: got %b expected %b", k, dut_vec, exp_vec);
      end
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("[TB] FAIL timeout_refund: got %0d pulses expected 1", pulses);
    end
  endtask

  task automatic test_empty();
    int iter = 0;
    while (m_stock > 0 && iter < 16) begin
      iter++;
      for (int k = 0; k < 8; k++) begin
        drive_cycle(0, k < 3, 0, 0, k == 3);
        checks++;
        if (dut_vec !== exp_vec) begin
          errors++; $display("[TB] FAIL empty_vend %0d k%0d: got %b expected %b", iter, k, dut_vec, exp_vec);
        end
      end
    end
    checks++;
    if (bus.po_empty !== 1'b1) begin
      errors++; $display("[TB] FAIL empty_flag: got %b expected 1", bus.po_empty);
    end
    for (int k = 0; k < 4; k++) begin
      drive_cycle(k == 0, 0, 0, k == 2, 0);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL empty_refill k%0d: got %b expected %b", k, dut_vec, exp_vec);
      end
    end
    checks++;
    if (bus.po_empty !== 1'b0 || bus.po_credit !== 4'd0) begin
      errors++; $display("[TB] FAIL refill_flag: got empty %b credit %0d expected 0 and 0", bus.po_empty, bus.po_credit);
    end
  endtask

  task automatic test_same_cycle();
    for (int k = 0; k < 10; k++) begin
      drive_cycle(k == 0 || k == 2 || k == 3, k == 1 || k == 2, k == 2, 0, k == 4);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL same_cycle k%0d: got %b expected %b", k, dut_vec, exp_vec);
      end
      if (k == 2) begin
        checks++;
        if (bus.po_cola !== 1'b1 || bus.po_credit !== 4'd1) begin
          errors++; $display("[TB] FAIL same_cycle_vend: got cola %b credit %0d expected 1 and 1", bus.po_cola, bus.po_credit);
        end
      end
      if (k == 3) begin
        checks++;
        if (bus.po_reject !== 1'b1) begin
          errors++; $display("[TB] FAIL dispense_reject: got %b expected 1", bus.po_reject);
        end
      end
    end
  endtask

  task automatic test_reset_refund();
    for (int k = 0; k < 4; k++) begin
      drive_cycle(0, k == 0, k == 1, 0, 0);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL reset_refund_pre k%0d: got %b expected %b", k, dut_vec, exp_vec);
      end
    end
    #2;
    sys_rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== 8'h00) begin
      errors++; $display("[TB] FAIL reset_refund_async: got %b expected %b", dut_vec, 8'h00);
    end
    @(posedge sys_clk);
    #1;
    sys_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_cycle(0, 0, 0, 0, 0);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL reset_refund_post k%0d: got %b expected %b", k, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    logic h, o, c, r, a;
    for (int k = 0; k < 3000; k++) begin
      h = ($urandom_range(0, 5) == 0);
      o = ($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 29) == 0);
      a = bus.po_cola ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 9) == 0);
      drive_cycle(h, o, c, r, a);
      checks++;
      if (dut_vec !== exp_vec) begin
        errors++; $display("[TB] FAIL random k%0d: got %b expected %b", k, dut_vec, exp_vec);
      end
    end
  endtask

  initial begin
    test_reset();
    test_half_coins();
    test_one_coins();
    test_cancel();
    test_timeout();
    test_empty();
    test_same_cycle();
    test_reset_refund();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
